// File: rtl/nrisc_control_fsm.sv
// Multi-cycle control unit and instruction register for the 8-bit nRisc core.
// Sequences FETCH/DECODE/EXEC/MEM/WB and drives register bank addresses directly.
module nrisc_control_fsm (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ready,
    input  logic       zero,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       mdr_write,
    output logic       pc_inc,
    output logic       pc_load,
    output logic [1:0] read1,
    output logic [1:0] read2,
    output logic [1:0] write_reg,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic [1:0] alu_op,
    output logic       alu_src_imm,
    output logic [7:0] imm,
    output logic [7:0] instr,
    output logic       halted,
    output logic [7:0] retired
);

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_HALT
    } opcode_t;

    state_t     state_q, state_d;
    logic [7:0] instr_q, instr_d;
    logic [7:0] retired_q, retired_d;
    opcode_t    op;
    logic       retire;

    assign op        = opcode_t'(instr_q[7:5]);
    assign instr     = instr_q;
    assign retired   = retired_q;
    assign read1     = instr_q[4:3];
    assign write_reg = instr_q[4:3];
    assign imm       = {{5{instr_q[2]}}, instr_q[2:0]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            instr_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    // Operand/ALU selects depend only on the opcode so they stay stable across EXEC and WB.
    always_comb begin
        alu_op      = 2'b00;
        alu_src_imm = 1'b0;
        read2       = instr_q[2:1];
        case (op)
            OP_SUB:  alu_op = 2'b01;
            OP_AND:  alu_op = 2'b10;
            OP_ADDI: begin
                alu_src_imm = 1'b1;
                read2       = 2'b00;
            end
            OP_BEQ: begin
                alu_op = 2'b01;
                read2  = 2'b00;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        retired_d  = retired_q;
        retire     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        mdr_write  = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    pc_inc  = 1'b1;
                    instr_d = mem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (op == OP_HALT) begin
                    state_d = ST_HALT;
                    retire  = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (op)
                    OP_LW, OP_SW: state_d = ST_MEM;
                    OP_BEQ: begin
                        pc_load = zero;
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                iord      = 1'b1;
                mem_read  = (op == OP_LW);
                mem_write = (op == OP_SW);
                if (mem_ready) begin
                    if (op == OP_LW) begin
                        mdr_write = 1'b1;
                        state_d   = ST_WB;
                    end else begin
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (op == OP_LW);
                state_d    = ST_FETCH;
                retire     = 1'b1;
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_FETCH;
        endcase

        if (retire) retired_d = retired_q + 8'd1;

        // Reset parks the state in FETCH; the strobes must still be quiet while it is held.
        if (reset) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            mdr_write = 1'b0;
            pc_inc    = 1'b0;
            pc_load   = 1'b0;
            reg_write = 1'b0;
        end
    end

endmodule

// File: doc/nrisc_control_fsm.md
# nrisc_control_fsm

Multi-cycle control unit and instruction register for the 8-bit nRisc core. It fetches each instruction over a ready-handshaked memory port and decodes it. It then sequences the datapath through DECODE/EXEC/MEM/WB and drives the register bank's read/write addresses and write enable directly, making it the stage immediately upstream of the register bank.

## Interface
- No parameters. Data width is fixed at 8, register address width at 2.
- clock  in  1  Single system clock; all state changes on rising edge.
- reset  in  1  Asynchronous, active-high.
- mem_rdata  in  8  Memory read data: the instruction in FETCH, the load data in MEM.
- mem_ready  in  1  Memory completes the current access when high at a rising edge.
- zero  in  1  ALU zero flag from the datapath; used only in EXEC of BEQ.
- mem_read, mem_write  out  1  Memory access strobes.
- iord  out  1  0 means the address is the PC, 1 means the address is the register read2 value.
- mdr_write  out  1  Datapath latches mem_rdata into its MDR.
- pc_inc  out  1  PC <= PC+1.
- pc_load  out  1  PC <= PC + imm; the datapath uses the already-incremented PC.
- read1, read2, write_reg  out  2  Register bank addresses.
- reg_write  out  1  Register bank write enable.
- mem_to_reg  out  1  Write-back source select: 1 selects the MDR, 0 selects the ALU result.
- alu_op  out  2  00 add, 01 sub, 10 and.
- alu_src_imm  out  1  ALU B operand: 1 selects imm, 0 selects the read2 data.
- imm  out  8  Sign-extended instr[2:0].
- instr  out  8  Instruction register contents.
- halted  out  1  High in HALT.
- retired  out  8  Count of retired instructions; wraps.

## Operation
- Fields: op = instr[7:5], ra = instr[4:3], rb = instr[2:1], imm3 = instr[2:0].
- Opcodes:
  - 000 ADD: ra <= ra + rb.
  - 001 SUB: ra <= ra - rb.
  - 010 AND: ra <= ra & rb.
  - 011 ADDI: ra <= ra + sext(imm3).
  - 100 LW: ra <= MEM[rb].
  - 101 SW: MEM[rb] <= ra.
  - 110 BEQ: if ra == R0, PC <= PC + sext(imm3).
  - 111 HALT.
- Register addresses:
  - read1 = ra in all states.
  - read2 = 0 for BEQ and ADDI, rb otherwise.
  - write_reg = ra.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - Asserts mem_read with iord=0.
  - In the cycle where mem_ready=1: pc_inc=1, IR <= mem_rdata, next state DECODE.
  - Otherwise the state holds with the strobes stable.
- DECODE: one cycle, no strobes. op 111 goes to HALT; every other op goes to EXEC.
- EXEC:
  - alu_op is 00 for ADD/ADDI/LW/SW, 01 for SUB/BEQ, 10 for AND.
  - alu_src_imm = 1 for ADDI only.
  - ADD/SUB/AND/ADDI go to WB. LW/SW go to MEM.
  - BEQ: pc_load = zero, then FETCH.
- MEM:
  - iord=1, with mem_read for LW or mem_write for SW.
  - Holds until mem_ready=1.
  - On mem_ready for LW: mdr_write=1, next state WB.
  - On mem_ready for SW: next state FETCH.
- WB: reg_write=1 for exactly one cycle, mem_to_reg=1 for LW only, next state FETCH.
- HALT: halted=1 with no strobes; only reset exits this state.
- retired increments by 1 on each of these transitions:
  - WB->FETCH.
  - MEM->FETCH (SW).
  - EXEC->FETCH (BEQ).
  - DECODE->HALT.
- retired wraps from 255 to 0.
- mem_ready is ignored outside FETCH and MEM.

## Timing
- Reset state:
  - State = FETCH, IR = 0x00, retired = 0.
  - While reset is high, all strobe outputs are forced to 0, including mem_read.
  - The first fetch strobe appears in the first cycle after reset is deasserted.
- All outputs are combinational from the state register and IR, except:
  - pc_inc and mdr_write also depend on mem_ready.
  - pc_load also depends on zero.
- Cycle counts with zero memory wait (mem_ready constantly 1):
  - ADD/SUB/AND/ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ: 3 cycles.
  - HALT reaches the HALT state after 2 cycles.
- Each wait cycle (mem_ready=0) in FETCH or MEM adds exactly 1 cycle.
- Reset mid-instruction:
  - The instruction is abandoned and outputs drop immediately (asynchronous reset).
  - No reg_write and no pc change occur.
  - retired is cleared.
- Only the cycle in which reg_write is high writes the register file. read1/read2 stay stable for that whole cycle.

## Test plan
- R-type, zero wait: reset, then fetch 0x08 (ADD r1,r0). Required response:
  - DECODE on cycle 2.
  - write_reg=1 and reg_write=1 on cycle 4 only.
  - retired=1 after cycle 4.
- ADDI sign-extension: instr 0x7F (ADDI r3,-1). Required response:
  - imm=0xFF, alu_src_imm=1, read2=0, write_reg=3.
  - Then instr 0x6B: imm=0x03, read1=1.
- LW with waits: instr 0x8A (LW r1,[r1]), mem_ready low for 2 cycles in FETCH and 3 cycles in MEM. Required response:
  - iord=1 throughout MEM.
  - mdr_write pulses once.
  - reg_write=1 with mem_to_reg=1 on cycle 10.
- BEQ taken and not taken: instr 0xD3 (BEQ r2,+3). Required response:
  - With zero=1: pc_load=1 in EXEC, alu_op=01, read2=0.
  - With zero=0: pc_load=0.
  - Both cases: next FETCH on cycle 4, retired incremented.
- Reset mid-SW: assert reset during MEM with mem_write=1. Required response:
  - mem_write=0 in the same cycle.
  - After release: state FETCH, retired=0, no reg_write seen.
- HALT and wrap: run 256 retiring instructions and check retired=0, then fetch 0xE0. Required response:
  - halted=1 on cycle 3 and stays high.
  - All strobes stay 0 for 20 further cycles.
  - retired=1.
